// File: rtl/corepwm_pkg.sv
// Shared constants and helpers for the CorePWM tachometer blocks.
package corepwm_pkg;

    localparam int unsigned TACH_PRESCALE_MAX = 11;
    localparam int unsigned TACH_NUM_MAX      = 16;
    localparam int unsigned TACH_PRESCALE_W   = 4;
    localparam int unsigned TACH_CNT_W        = 12;

    // Low-bit mask for the effective exponent min(p, TACH_PRESCALE_MAX).
    function automatic logic [TACH_CNT_W-1:0] prescale_mask(input logic [TACH_PRESCALE_W-1:0] p);
        int unsigned e;
        logic [TACH_CNT_W-1:0] one;
        e   = (int'(p) > int'(TACH_PRESCALE_MAX)) ? TACH_PRESCALE_MAX : int'(p);
        one = TACH_CNT_W'(1);
        return (one << e) - one;
    endfunction

endpackage

// File: rtl/corepwm_tach_prescale.sv
// Power-of-two prescaler producing the shared one-PCLK tach sampling strobe.
module corepwm_tach_prescale
    import corepwm_pkg::*;
(
    input  logic                       PCLK,
    input  logic                       PRESETN,
    input  logic [TACH_PRESCALE_W-1:0] TACHPRESCALE,
    output logic                       tach_cnt_clk
);

    logic [TACH_CNT_W-1:0]      cnt_q, cnt_d;
    logic [TACH_PRESCALE_W-1:0] pre_q, pre_d;
    logic                       strobe_q, strobe_d;
    logic                       changed;
    logic [TACH_CNT_W-1:0]      mask;

    always_comb begin
        changed  = (TACHPRESCALE != pre_q);
        mask     = prescale_mask(TACHPRESCALE);
        pre_d    = TACHPRESCALE;
        cnt_d    = changed ? '0 : cnt_q + TACH_CNT_W'(1);
        // A prescale change restarts the period and drops any strobe due now.
        strobe_d = !changed && ((cnt_q & mask) == mask);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cnt_q    <= '0;
            pre_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            strobe_q <= strobe_d;
        end
    end

    assign tach_cnt_clk = strobe_q;

endmodule

// File: rtl/corepwm_tach_ctrl.sv
// Shared tach control: prescaler, sticky W1C status, interrupt mask and TACHINT.
// Define COREPWM_TACH_IRQ_REG_EN to register TACHINT (one PCLK of added latency).
module corepwm_tach_ctrl
    import corepwm_pkg::*;
#(
    parameter int unsigned TACH_NUM = 1
) (
    input  logic                       PCLK,
    input  logic                       PRESETN,
    input  logic [TACH_PRESCALE_W-1:0] TACHPRESCALE,
    input  logic [TACH_NUM-1:0]        update_status,
    input  logic                       stat_wr,
    input  logic [TACH_NUM-1:0]        stat_wdata,
    input  logic                       mask_wr,
    input  logic [TACH_NUM-1:0]        mask_wdata,
    output logic                       tach_cnt_clk,
    output logic [TACH_NUM-1:0]        TACHSTATUS,
    output logic [TACH_NUM-1:0]        status_clear,
    output logic [TACH_NUM-1:0]        TACHIRQMASK,
    output logic                       TACHINT
);

    logic [TACH_NUM-1:0] upd_q, upd_d;
    logic [TACH_NUM-1:0] stat_q, stat_d;
    logic [TACH_NUM-1:0] mask_q, mask_d;
    logic                irq_d;

    corepwm_tach_prescale u_prescale (
        .PCLK         (PCLK),
        .PRESETN      (PRESETN),
        .TACHPRESCALE (TACHPRESCALE),
        .tach_cnt_clk (tach_cnt_clk)
    );

    // Edge detect keeps a long update_status level from re-setting after a clear.
    for (genvar i = 0; i < TACH_NUM; i++) begin : g_chan
        logic set, clr;
        assign set       = update_status[i] & ~upd_q[i];
        assign clr       = stat_wr & stat_wdata[i];
        assign stat_d[i] = set ? 1'b1 : (clr ? 1'b0 : stat_q[i]);
    end

    always_comb begin
        upd_d  = update_status;
        mask_d = mask_wr ? mask_wdata : mask_q;
        irq_d  = |(stat_q & mask_q);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            upd_q  <= '0;
            stat_q <= '0;
            mask_q <= '0;
        end else begin
            upd_q  <= upd_d;
            stat_q <= stat_d;
            mask_q <= mask_d;
        end
    end

`ifdef COREPWM_TACH_IRQ_REG_EN
    logic int_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            int_q <= 1'b0;
        end else begin
            int_q <= irq_d;
        end
    end

    assign TACHINT = int_q;
`else
    assign TACHINT = irq_d;
`endif

    assign TACHSTATUS   = stat_q;
    assign status_clear = ~stat_q;
    assign TACHIRQMASK  = mask_q;

endmodule

// File: tb/tb_corepwm_tach_ctrl.sv
// Directed self-checking bench for corepwm_tach_ctrl with four channels.
module tb_corepwm_tach_ctrl;

    localparam int unsigned N = 4;

    logic         PCLK = 1'b0;
    logic         PRESETN = 1'b0;
    logic [3:0]   TACHPRESCALE = '0;
    logic [N-1:0] update_status = '0;
    logic         stat_wr = 1'b0;
    logic [N-1:0] stat_wdata = '0;
    logic         mask_wr = 1'b0;
    logic [N-1:0] mask_wdata = '0;
    logic         tach_cnt_clk;
    logic [N-1:0] TACHSTATUS;
    logic [N-1:0] status_clear;
    logic [N-1:0] TACHIRQMASK;
    logic         TACHINT;

    int errors = 0;
    int checks = 0;

    corepwm_tach_ctrl #(.TACH_NUM(N)) dut (
        .PCLK          (PCLK),
        .PRESETN       (PRESETN),
        .TACHPRESCALE  (TACHPRESCALE),
        .update_status (update_status),
        .stat_wr       (stat_wr),
        .stat_wdata    (stat_wdata),
        .mask_wr       (mask_wr),
        .mask_wdata    (mask_wdata),
        .tach_cnt_clk  (tach_cnt_clk),
        .TACHSTATUS    (TACHSTATUS),
        .status_clear  (status_clear),
        .TACHIRQMASK   (TACHIRQMASK),
        .TACHINT       (TACHINT)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Edges counted from the call until tach_cnt_clk is seen high; -1 on timeout.
    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        forever begin
            tick();
            n++;
            if (tach_cnt_clk) break;
            if (n >= limit) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic restart(input logic [3:0] p);
        PRESETN      = 1'b0;
        TACHPRESCALE = p;
        tick();
        PRESETN = 1'b1;
    endtask

    int n;
    int e;

    initial begin
        // Reset state
        tick();
        check("rst_status", TACHSTATUS, 0);
        check("rst_sclr", status_clear, 4'hF);
        check("rst_mask", TACHIRQMASK, 0);
        check("rst_int", TACHINT, 0);
        check("rst_strobe", tach_cnt_clk, 0);

        // Prescale sweep. The registered copy resets to 0, so a nonzero
        // prescale held through reset is a change seen on edge 1, and the
        // first strobe then lands 2^e edges after that.
        restart(4'd0);
        wait_strobe(8, n);
        check("p0_first", n, 1);
        wait_strobe(8, n);
        check("p0_period", n, 1);

        restart(4'd3);
        wait_strobe(20, n);
        check("p3_first", n, 9);
        wait_strobe(20, n);
        check("p3_period", n, 8);
        wait_strobe(20, n);
        check("p3_period2", n, 8);

        restart(4'd15);
        wait_strobe(2100, n);
        check("p15_first", n, 2049);
        wait_strobe(2100, n);
        check("p15_period", n, 2048);

        // Prescale change 3 -> 1 mid-period
        restart(4'd3);
        wait_strobe(20, n);
        tick();
        tick();
        tick();
        TACHPRESCALE = 4'd1;
        tick();
        check("chg_suppress", tach_cnt_clk, 0);
        wait_strobe(10, n);
        check("chg_first", n, 2);
        wait_strobe(10, n);
        check("chg_period", n, 2);
        wait_strobe(10, n);
        check("chg_period2", n, 2);

        // Sticky status with update_status[0] held high for 20 cycles
        update_status = 4'b0001;
        tick();
        check("set0_status", TACHSTATUS, 4'h1);
        check("set0_sclr", status_clear, 4'hE);
        tick();
        tick();
        check("set0_hold", TACHSTATUS, 4'h1);
        stat_wr    = 1'b1;
        stat_wdata = 4'h1;
        tick();
        stat_wr    = 1'b0;
        stat_wdata = '0;
        check("w1c0_status", TACHSTATUS, 4'h0);
        for (int i = 0; i < 16; i++) tick();
        check("w1c0_stays", TACHSTATUS, 4'h0);
        check("w1c0_sclr", status_clear, 4'hF);
        update_status = '0;
        tick();

        // Zero-data W1C and collision of set with clear on channel 1
        update_status = 4'b0010;
        tick();
        update_status = '0;
        tick();
        check("set1_status", TACHSTATUS, 4'h2);
        stat_wr    = 1'b1;
        stat_wdata = 4'h0;
        tick();
        check("w1c_zero", TACHSTATUS, 4'h2);
        update_status = 4'b0010;
        stat_wdata    = 4'h2;
        tick();
        stat_wr       = 1'b0;
        stat_wdata    = '0;
        update_status = '0;
        check("collide_set", TACHSTATUS, 4'h2);

        // Interrupt masking
        update_status = 4'b0001;
        tick();
        update_status = '0;
        mask_wr       = 1'b1;
        mask_wdata    = 4'h4;
        tick();
        mask_wr    = 1'b0;
        mask_wdata = '0;
        check("irq_status3", TACHSTATUS, 4'h3);
        check("irq_mask", TACHIRQMASK, 4'h4);
        tick();
        check("irq_masked", TACHINT, 0);
        update_status = 4'b0100;
        tick();
        update_status = '0;
        check("irq_status7", TACHSTATUS, 4'h7);
`ifdef COREPWM_TACH_IRQ_REG_EN
        check("irq_lat0", TACHINT, 0);
        tick();
`endif
        check("irq_set", TACHINT, 1);
        stat_wr    = 1'b1;
        stat_wdata = 4'h4;
        tick();
        stat_wr    = 1'b0;
        stat_wdata = '0;
        check("irq_w1c_status", TACHSTATUS, 4'h3);
`ifdef COREPWM_TACH_IRQ_REG_EN
        check("irq_lat1", TACHINT, 1);
        tick();
`endif
        check("irq_cleared", TACHINT, 0);

        // Asynchronous reset with status 0xF and full mask
        update_status = 4'hF;
        mask_wr       = 1'b1;
        mask_wdata    = 4'hF;
        tick();
        update_status = '0;
        mask_wr       = 1'b0;
        mask_wdata    = '0;
        tick();
        check("pre_rst_status", TACHSTATUS, 4'hF);
        check("pre_rst_int", TACHINT, 1);
        wait_strobe(10, n);
        #2;
        PRESETN = 1'b0;
        #1;
        check("arst_status", TACHSTATUS, 0);
        check("arst_sclr", status_clear, 4'hF);
        check("arst_mask", TACHIRQMASK, 0);
        check("arst_int", TACHINT, 0);
        check("arst_strobe", tach_cnt_clk, 0);

        // Release with update_status[0] high: counts as a rising edge
        update_status = 4'b0001;
        TACHPRESCALE  = 4'd1;
        tick();
        PRESETN = 1'b1;
        tick();
        check("rel_edge_status", TACHSTATUS, 4'h1);
        // Edge 1 already consumed; prescale 1 differs from reset copy 0
        wait_strobe(10, n);
        check("rel_strobe", n, 2);
        wait_strobe(10, n);
        check("rel_period", n, 2);
        update_status = '0;

        e = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
